// File: rtl/div32_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock, 33-clock latency
// (1 clock for divide-by-zero). Quotient goes to LO and remainder to HI.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        abs_dividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_divisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        // shifted < 2*divisor, so the 33-bit difference never overflows its sign bit
        shifted      = {rem_q, quo_q[WIDTH-1]};
        trial        = shifted - {1'b0, dvsr_q};

        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvsr_d        = dvsr_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_pend_d    = dbz_pend_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvsr_d    = abs_divisor;
                    neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = signed_op & dividend[WIDTH-1];
                    if (divisor == '0) begin
                        // Raw dividend parks in the quotient work register for the HI result
                        state_d    = S_FIN;
                        dbz_pend_d = 1'b1;
                        quo_d      = dividend;
                    end else begin
                        state_d    = S_RUN;
                        dbz_pend_d = 1'b0;
                        quo_d      = abs_dividend;
                    end
                end
            end
            S_RUN: begin
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dbz_pend_q) begin
                    quotient_d    = '1;
                    remainder_d   = quo_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = neg_quo_q ? -quo_q : quo_q;
                    remainder_d   = neg_rem_q ? -rem_q : rem_q;
                    div_by_zero_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvsr_q        <= dvsr_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_pend_q    <= dbz_pend_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed MIPS corner cases plus randomized operands
// checked against an arithmetic reference (C-style truncating signed division).
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int exp_done = 0;

    div32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    // Reference: divide-by-zero convention, else plain integer arithmetic
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1;
        end else if (s) begin
            sa = a; sb = b;
            la = longint'(sa); lb = longint'(sb);
            lq = la / lb; lr = la % lb;
            q = lq[31:0]; r = lr[31:0]; z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    // Presents operands, takes the accept edge, then scrambles the inputs
    task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1; dividend = a; divisor = b; signed_op = s;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
    endtask

    task automatic wait_done(input int already, output int lat, output logic busy_ok);
        lat = already; busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            failures++;
            $display("FAIL reset_hold: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b done=%b q=%h r=%h, want all 0",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic        ts [5];
        logic [31:0] eq [5];
        logic [31:0] er [5];
        int lat; logic bok;
        ta = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd0};
        tb = '{32'd7,   32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9};
        ts = '{1'b0,    1'b1,          1'b1,          1'b0,          1'b1};
        eq = '{32'd14,  32'hFFFF_FFFD, 32'h8000_0000, 32'd0,         32'd0};
        er = '{32'd2,   32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32'd0};
        for (int i = 0; i < 5; i++) begin
            accept_op(ta[i], tb[i], ts[i]);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL dir_busy_after_accept[%0d]: got %b want 1", i, busy);
            end
            wait_done(0, lat, bok);
            exp_done++;
            $display("directed %0d: %h / %h s=%b -> q=%h r=%h lat=%0d", i, ta[i], tb[i], ts[i],
                     quotient, remainder, lat);
            checks++;
            if (lat !== 33 || bok !== 1'b1) begin
                failures++;
                $display("FAIL dir_latency[%0d]: got lat=%0d busy_ok=%b want 33/1", i, lat, bok);
            end
            checks++;
            if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL dir_result[%0d]: got q=%h r=%h dbz=%b want q=%h r=%h dbz=0",
                         i, quotient, remainder, div_by_zero, eq[i], er[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq[i]) begin
                failures++;
                $display("FAIL dir_pulse_hold[%0d]: got done=%b busy=%b q=%h want 0/0/%h",
                         i, done, busy, quotient, eq[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int lat; logic bok;
        accept_op(32'd5, 32'd0, 1'b0);
        wait_done(0, lat, bok);
        exp_done++;
        $display("dbz: 5 / 0 -> q=%h r=%h dbz=%b lat=%0d", quotient, remainder, div_by_zero, lat);
        checks++;
        if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result: got lat=%0d q=%h r=%h dbz=%b want 1/ffffffff/5/1",
                     lat, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        accept_op(32'd20, 32'd6, 1'b0);
        wait_done(0, lat, bok);
        exp_done++;
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== 32'd3 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL dbz_clear: got dbz=%b q=%h r=%h want 0/3/2", div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_ignore_start;
        int lat; logic bok;
        @(posedge clk); #1;
        accept_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd9; divisor = 32'd3; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(10, lat, bok);
        exp_done++;
        $display("ignore: 100 / 7 with start at E10 -> q=%h r=%h lat=%0d", quotient, remainder, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL ignore_busy_start: got lat=%0d q=%h r=%h want 33/14/2", lat, quotient, remainder);
        end
        accept_op(32'd9, 32'd3, 1'b0);
        wait_done(0, lat, bok);
        exp_done++;
        $display("b2b: 9 / 3 accepted in done cycle -> q=%h r=%h lat=%0d", quotient, remainder, lat);
        checks++;
        if (lat !== 33 || quotient !== 32'd3 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL done_cycle_accept: got lat=%0d q=%h r=%h want 33/3/0", lat, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat; logic bok; int seen;
        @(posedge clk); #1;
        accept_op(32'd1000, 32'd3, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid_op: got busy=%b q=%h r=%h want all 0", busy, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = done_count;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_count !== seen || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: got done pulses=%0d busy=%b want 0/0", done_count - seen, busy);
        end
        accept_op(32'd77, 32'd5, 1'b0);
        wait_done(0, lat, bok);
        exp_done++;
        checks++;
        if (lat !== 33 || quotient !== 32'd15 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL reset_recover: got lat=%0d q=%h r=%h want 33/f/2", lat, quotient, remainder);
        end
    endtask

    // Random operands; back_to_back=1 launches each op in the previous op's done cycle
    task automatic test_random(input int n, input logic back_to_back);
        logic [31:0] a, b, eq, er;
        logic s, ez, bok;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = $urandom; s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            ref_div(a, b, s, eq, er, ez);
            if (!back_to_back) begin
                @(posedge clk); #1;
            end
            accept_op(a, b, s);
            wait_done(0, lat, bok);
            exp_done++;
            $display("rand%0s %0d: %h / %h s=%b -> q=%h r=%h dbz=%b lat=%0d",
                     back_to_back ? "_b2b" : "", i, a, b, s, quotient, remainder, div_by_zero, lat);
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                failures++;
                $display("FAIL rand_result[%0d]: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         i, quotient, remainder, div_by_zero, eq, er, ez);
            end
            checks++;
            if (lat !== ((b == 32'd0) ? 1 : 33) || bok !== 1'b1) begin
                failures++;
                $display("FAIL rand_latency[%0d]: got lat=%0d busy_ok=%b want %0d/1",
                         i, lat, bok, (b == 32'd0) ? 1 : 33);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div_by_zero;
        test_ignore_start;
        test_reset_mid_op;
        test_random(30, 1'b0);
        test_random(12, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_count !== exp_done) begin
            failures++;
            $display("FAIL done_pulse_count: got %0d want %0d", done_count, exp_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
